alu_reservation_station: RTL

- Reservation station that feeds the integer ALU execution unit: holds dispatched ALU/compare micro-ops, captures operand values from the common data bus (CDB), and issues one ready op per cycle as an rs_data_pkt_t plus rs1/rs2 values.
- Sits between dispatch/rename and the ALU; the ALU result is tagged with issue_rob_tag on its way to the CDB.

---
 rtl/alu_reservation_station_pkg.sv | 55 +++++
 rtl/alu_reservation_station_priority_select.sv | 22 ++
 rtl/alu_reservation_station.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_pkg.sv
// ============================================================================
// Module : alu_reservation_station_pkg
// Brief  : Shared types for the ALU reservation station (op packet, entry).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_reservation_station_pkg;

   localparam int ROB_TAG_WIDTH = 5;

   typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;

   typedef enum logic [2:0] {
      alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
      alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
   } alu_ops_t;

   typedef enum logic [2:0] {
      cmp_beq  = 3'b000, cmp_bne  = 3'b001, cmp_blt = 3'b100,
      cmp_bge  = 3'b101, cmp_bltu = 3'b110, cmp_bgeu = 3'b111
   } cmp_ops_t;

   typedef enum logic {rs1_out = 1'b0, pc_out  = 1'b1} alu_m1_sel_t;
   typedef enum logic {rs2_out = 1'b0, imm_out = 1'b1} alu_m2_sel_t;

   typedef struct packed {
      alu_m1_sel_t alu_m1_sel;
      alu_m2_sel_t alu_m2_sel;
   } alu_op_sel_t;

   typedef struct packed {
      alu_ops_t    aluop;
      cmp_ops_t    cmpop;
      logic        i_use_alu_cmpop;
      alu_op_sel_t alu_op_sel;
      logic [31:0] pc;
      logic [31:0] imm_data;
   } rs_data_pkt_t;

   typedef struct packed {
      logic         valid;
      rs_data_pkt_t pkt;
      rob_tag_t     rob_tag;
      logic         rs1_rdy;
      rob_tag_t     rs1_tag;
      logic [31:0]  rs1_data;
      logic         rs2_rdy;
      rob_tag_t     rs2_tag;
      logic [31:0]  rs2_data;
   } rs_entry_t;

endpackage

`default_nettype wire

// File: rtl/alu_reservation_station_priority_select.sv
// ============================================================================
// Module : rs_priority_select
// Brief  : Lowest-index one-hot picker with a found flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rs_priority_select #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_onehot,
   output logic         o_found
);

   // Two's-complement trick isolates the lowest set bit.
   assign o_onehot = i_req & (~i_req + {{(N-1){1'b0}}, 1'b1});
   assign o_found  = |i_req;

endmodule

`default_nettype wire

// File: rtl/alu_reservation_station.sv
// ============================================================================
// Module : alu_reservation_station
// Brief  : ALU reservation station: CDB operand capture, lowest-index issue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_reservation_station
   import alu_reservation_station_pkg::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int ROB_TAG_W   = ROB_TAG_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 dispatch_valid,
   output logic                 dispatch_ready,
   input  rs_data_pkt_t         dispatch_pkt,
   input  logic [ROB_TAG_W-1:0] dispatch_rob_tag,
   input  logic                 dispatch_rs1_rdy,
   input  logic                 dispatch_rs2_rdy,
   input  logic [ROB_TAG_W-1:0] dispatch_rs1_tag,
   input  logic [ROB_TAG_W-1:0] dispatch_rs2_tag,
   input  logic [31:0]          dispatch_rs1_data,
   input  logic [31:0]          dispatch_rs2_data,
   input  logic                 cdb_valid,
   input  logic [ROB_TAG_W-1:0] cdb_tag,
   input  logic [31:0]          cdb_data,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output rs_data_pkt_t         issue_pkt,
   output logic [31:0]          issue_rs1_data,
   output logic [31:0]          issue_rs2_data,
   output logic [ROB_TAG_W-1:0] issue_rob_tag
);

   typedef struct packed {
      logic                 valid;
      rs_data_pkt_t         pkt;
      logic [ROB_TAG_W-1:0] rob_tag;
      logic                 rs1_rdy;
      logic [ROB_TAG_W-1:0] rs1_tag;
      logic [31:0]          rs1_data;
      logic                 rs2_rdy;
      logic [ROB_TAG_W-1:0] rs2_tag;
      logic [31:0]          rs2_data;
   } entry_t;

   entry_t                 r_ent [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] w_free;
   logic [NUM_ENTRIES-1:0] w_ready;
   logic [NUM_ENTRIES-1:0] w_free_oh;
   logic [NUM_ENTRIES-1:0] w_iss_oh;
   logic                   w_free_found;
   logic                   w_iss_found;
   logic                   w_disp_fire;
   logic                   w_iss_fire;
   entry_t                 w_new;
   entry_t                 w_sel;

   always_comb begin
      w_free  = '0;
      w_ready = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         w_free[i]  = ~r_ent[i].valid;
         w_ready[i] = r_ent[i].valid & r_ent[i].rs1_rdy & r_ent[i].rs2_rdy;
      end
   end

   rs_priority_select #(.N(NUM_ENTRIES)) u_free_sel (
      .i_req    (w_free),
      .o_onehot (w_free_oh),
      .o_found  (w_free_found)
   );

   rs_priority_select #(.N(NUM_ENTRIES)) u_issue_sel (
      .i_req    (w_ready),
      .o_onehot (w_iss_oh),
      .o_found  (w_iss_found)
   );

   assign dispatch_ready = w_free_found;
   assign issue_valid    = w_iss_found;
   assign w_disp_fire    = dispatch_valid & w_free_found;
   assign w_iss_fire     = w_iss_found & issue_ready;

   // New entry, with same-cycle CDB bypass into any still-waiting operand.
   always_comb begin
      w_new          = '0;
      w_new.valid    = 1'b1;
      w_new.pkt      = dispatch_pkt;
      w_new.rob_tag  = dispatch_rob_tag;
      w_new.rs1_rdy  = dispatch_rs1_rdy;
      w_new.rs1_tag  = dispatch_rs1_tag;
      w_new.rs1_data = dispatch_rs1_data;
      w_new.rs2_rdy  = dispatch_rs2_rdy;
      w_new.rs2_tag  = dispatch_rs2_tag;
      w_new.rs2_data = dispatch_rs2_data;
      if (cdb_valid && !dispatch_rs1_rdy && dispatch_rs1_tag == cdb_tag) begin
         w_new.rs1_rdy  = 1'b1;
         w_new.rs1_data = cdb_data;
      end
      if (cdb_valid && !dispatch_rs2_rdy && dispatch_rs2_tag == cdb_tag) begin
         w_new.rs2_rdy  = 1'b1;
         w_new.rs2_data = cdb_data;
      end
   end

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (w_iss_oh[i]) w_sel = r_ent[i];
      end
   end

   assign issue_pkt      = w_sel.pkt;
   assign issue_rs1_data = w_sel.rs1_data;
   assign issue_rs2_data = w_sel.rs2_data;
   assign issue_rob_tag  = w_sel.rob_tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_disp_fire && w_free_oh[i]) begin
               r_ent[i] <= w_new;
            end else begin
               if (w_iss_fire && w_iss_oh[i]) r_ent[i].valid <= 1'b0;
               if (cdb_valid && r_ent[i].valid && !r_ent[i].rs1_rdy &&
                   r_ent[i].rs1_tag == cdb_tag) begin
                  r_ent[i].rs1_rdy  <= 1'b1;
                  r_ent[i].rs1_data <= cdb_data;
               end
               if (cdb_valid && r_ent[i].valid && !r_ent[i].rs2_rdy &&
                   r_ent[i].rs2_tag == cdb_tag) begin
                  r_ent[i].rs2_rdy  <= 1'b1;
                  r_ent[i].rs2_data <= cdb_data;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire
